keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 129 ++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan + 2-flop sync + debounce; ev <= SCAN_DIV+2+DEBOUNCE_CYCLES+1 cycles after a stable press.
// No back-pressure: one ev per press, spaced >= 2*DEBOUNCE_CYCLES+SCAN_DIV cycles by the release debounce.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kp_col_in,
    output logic [3:0] kp_row_out,
    output logic [3:0] col,
    output logic [3:0] row,
    output logic       ev
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        FIRE     = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] DEB_TARGET = 16'(DEBOUNCE_CYCLES);

    state_t      state_q;
    logic [3:0]  sync1_q;
    logic [3:0]  col_s_q;
    logic [3:0]  row_drv_q;
    logic [3:0]  cand_q;
    logic [3:0]  col_q;
    logic [3:0]  row_q;
    logic        ev_q;
    logic [15:0] dwell_q;
    logic [15:0] cnt_q;
    logic [15:0] rel_q;

    logic        one_cold_d;
    logic [3:0]  row_rot_d;
    logic [15:0] cnt_inc_d;
    logic [15:0] rel_inc_d;

    always_comb begin
        one_cold_d = 1'b0;
        case (col_s_q)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_cold_d = 1'b1;
            default:                            one_cold_d = 1'b0;
        endcase
        row_rot_d = {row_drv_q[2:0], row_drv_q[3]};
        cnt_inc_d = cnt_q + 16'd1;
        rel_inc_d = rel_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SCAN;
            sync1_q   <= 4'b1111;
            col_s_q   <= 4'b1111;
            row_drv_q <= 4'b1110;
            cand_q    <= 4'b1111;
            col_q     <= 4'b1111;
            row_q     <= 4'b1111;
            ev_q      <= 1'b0;
            dwell_q   <= 16'd0;
            cnt_q     <= 16'd0;
            rel_q     <= 16'd0;
        end else begin
            sync1_q <= kp_col_in;
            col_s_q <= sync1_q;
            ev_q    <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= 16'd0;
                        if (one_cold_d) begin
                            // Row stays driven so the debounce keeps watching the same key.
                            cand_q  <= col_s_q;
                            cnt_q   <= 16'd1;
                            state_q <= DEBOUNCE;
                        end else begin
                            row_drv_q <= row_rot_d;
                        end
                    end else begin
                        dwell_q <= dwell_q + 16'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s_q == cand_q) begin
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d == DEB_TARGET) begin
                            state_q <= FIRE;
                            col_q   <= cand_q;
                            row_q   <= row_drv_q;
                            ev_q    <= 1'b1;
                        end
                    end else begin
                        state_q   <= SCAN;
                        row_drv_q <= row_rot_d;
                        dwell_q   <= 16'd0;
                    end
                end
                FIRE: begin
                    state_q <= HOLD;
                    rel_q   <= 16'd0;
                end
                HOLD: begin
                    // Only the held row is driven, so keys on other rows are invisible here.
                    if (col_s_q == 4'b1111) begin
                        rel_q <= rel_inc_d;
                        if (rel_inc_d == DEB_TARGET) begin
                            state_q   <= SCAN;
                            row_drv_q <= row_rot_d;
                            dwell_q   <= 16'd0;
                        end
                    end else begin
                        rel_q <= 16'd0;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp_row_out = row_drv_q;
    assign col        = col_q;
    assign row        = row_q;
    assign ev         = ev_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, scoreboard queue of expected {col,row} per ev.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] kp_col_in;
    logic [3:0] kp_row_out;
    logic [3:0] col;
    logic [3:0] row;
    logic       ev;

    logic       key_on;
    logic [3:0] key_row;
    logic [3:0] key_col;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ev_cnt = 0;
    int last_ev = -1;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // A key pulls its column low only while its row is driven low.
    assign kp_col_in = (key_on && kp_row_out == key_row) ? key_col : 4'b1111;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .kp_col_in  (kp_col_in),
        .kp_row_out (kp_row_out),
        .col        (col),
        .row        (row),
        .ev         (ev)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!(kp_row_out == 4'b1110 || kp_row_out == 4'b1101 ||
                  kp_row_out == 4'b1011 || kp_row_out == 4'b0111)) begin
                errors++;
                $display("FAIL row_one_cold got=%b want=one-cold", kp_row_out);
            end
            if (ev === 1'b1) begin
                ev_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ev got col=%b row=%b want no event", col, row);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({col, row} !== exp_e) begin
                        errors++;
                        $display("FAIL ev_pattern got col=%b row=%b want col=%b row=%b",
                                 col, row, exp_e[7:4], exp_e[3:0]);
                    end
                end
                if (last_ev >= 0) begin
                    checks++;
                    if (cyc - last_ev < 20) begin
                        errors++;
                        $display("FAIL ev_spacing got=%0d want>=20", cyc - last_ev);
                    end
                end
                last_ev = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic wait_ev(input string name, input int bound);
        int start;
        int n;
        start = ev_cnt;
        n = 0;
        while (ev_cnt == start && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ev_cnt == start) begin
            errors++;
            $display("FAIL %s got=no ev want=ev within %0d cycles", name, bound);
        end
    endtask

    initial begin
        int seen_a;
        int seen_b;
        reset   = 1'b1;
        key_on  = 1'b0;
        key_row = 4'b1111;
        key_col = 4'b1111;

        // Reset values and row rotation.
        tick(3);
        chk("rst_row_out", kp_row_out, 4'b1110);
        chk("rst_col", col, 4'b1111);
        chk("rst_row", row, 4'b1111);
        chk("rst_ev", {3'b000, ev}, 4'b0000);
        mon_en = 1'b1;
        reset  = 1'b0;
        tick(3);
        chk("rot_hold", kp_row_out, 4'b1110);
        tick(1);
        chk("rot_1", kp_row_out, 4'b1101);
        tick(4);
        chk("rot_2", kp_row_out, 4'b1011);
        tick(4);
        chk("rot_3", kp_row_out, 4'b0111);
        tick(4);
        chk("rot_wrap", kp_row_out, 4'b1110);

        // Key "8" pressed and held: one event, no auto-repeat.
        key_row = 4'b0111;
        key_col = 4'b1011;
        exp_q.push_back({4'b1011, 4'b0111});
        key_on = 1'b1;
        wait_ev("key8_ev", 100);
        tick(200);
        key_on = 1'b0;
        tick(20);

        // Bouncing contact, then stable.
        key_row = 4'b1101;
        key_col = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            key_on = 1'b1;
            tick(3);
            key_on = 1'b0;
            tick(3);
        end
        exp_q.push_back({4'b1011, 4'b1101});
        key_on = 1'b1;
        wait_ev("bounce_ev", 100);
        key_on = 1'b0;
        tick(20);

        // Two keys on one row: ignored, scanning continues.
        key_row = 4'b1101;
        key_col = 4'b0011;
        key_on  = 1'b1;
        seen_a = 0;
        seen_b = 0;
        repeat (60) begin
            tick(1);
            if (kp_row_out == 4'b1101) seen_a++;
            if (kp_row_out == 4'b0111) seen_b++;
        end
        chk("two_key_row_seen", {3'b000, seen_a > 0}, 4'b0001);
        chk("two_key_rotates", {3'b000, seen_b > 0}, 4'b0001);
        key_on = 1'b0;
        tick(10);

        // Key "5" pressed, released, pressed again.
        key_row = 4'b1011;
        key_col = 4'b1011;
        exp_q.push_back({4'b1011, 4'b1011});
        exp_q.push_back({4'b1011, 4'b1011});
        key_on = 1'b1;
        wait_ev("key5_first", 100);
        tick(10);
        key_on = 1'b0;
        tick(16);
        key_on = 1'b1;
        wait_ev("key5_second", 100);
        key_on = 1'b0;
        tick(20);

        // Reset while debouncing (cnt=5 after 8 edges) discards the press.
        reset   = 1'b1;
        key_row = 4'b1110;
        key_col = 4'b0111;
        key_on  = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(8);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_row_out", kp_row_out, 4'b1110);
        chk("mid_rst_col", col, 4'b1111);
        chk("mid_rst_row", row, 4'b1111);
        chk("mid_rst_ev", {3'b000, ev}, 4'b0000);
        key_on = 1'b0;
        reset  = 1'b0;
        tick(3);
        chk("resume_row0", kp_row_out, 4'b1110);
        tick(1);
        chk("resume_row1", kp_row_out, 4'b1101);
        tick(30);

        // Exact latency from reset release with the key already down.
        reset  = 1'b1;
        key_on = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.push_back({4'b0111, 4'b1110});
        tick(10);
        chk("lat_early", {3'b000, ev}, 4'b0000);
        tick(1);
        chk("lat_exact", {3'b000, ev}, 4'b0001);
        chk("lat_col", col, 4'b0111);
        chk("lat_row", row, 4'b1110);
        tick(1);
        chk("ev_one_cycle", {3'b000, ev}, 4'b0000);
        key_on = 1'b0;
        tick(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_ev got=%0d pending want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=timeout want=finish");
        $fatal(1, "timeout");
    end

endmodule
